// File: rtl/eth_frame_pkg.sv
// Shared Ethernet framing definitions: nibble markers, control-block layout
// and the receive deframer state encoding.
package eth_frame_pkg;

    localparam logic [3:0] PREAMBLE_NIB = 4'h5;
    localparam logic [3:0] SFD_HI_NIB   = 4'hD;

    localparam int LEN_W  = 12;
    localparam int CTRL_W = 2 * LEN_W;

    localparam int CTRL_LEN_HI_MSB = 23;
    localparam int CTRL_LEN_HI_LSB = 12;
    localparam int CTRL_LEN_LO_MSB = 11;
    localparam int CTRL_LEN_LO_LSB = 0;

    localparam logic [LEN_W-1:0] LEN_SAT = '1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2,
        DROP     = 2'd3
    } rx_state_t;

    // Length is carried twice so the transmit side can cross-check the block.
    function automatic logic [CTRL_W-1:0] pack_ctrl(input logic [LEN_W-1:0] len);
        logic [CTRL_W-1:0] ctrl;
        ctrl = '0;
        ctrl[CTRL_LEN_HI_MSB:CTRL_LEN_HI_LSB] = len;
        ctrl[CTRL_LEN_LO_MSB:CTRL_LEN_LO_LSB] = len;
        return ctrl;
    endfunction

endpackage

// File: rtl/rx_nibble_pack.sv
// Packs a low-nibble-first stream into bytes; the byte and its valid pulse
// appear one clock after the high nibble is sampled.
module rx_nibble_pack
    import eth_frame_pkg::*;
(
    input  logic       clk_phy,
    input  logic       reset,
    input  logic       clear,
    input  logic       en,
    input  logic [3:0] nib_in,
    output logic       phase,
    output logic       byte_done,
    output logic [7:0] data_out,
    output logic       data_valid
);

    logic [3:0] low_nib;

    assign byte_done = en & phase;

    always_ff @(posedge clk_phy or negedge reset) begin
        if (!reset) begin
            phase <= 1'b0;
        end else if (clear) begin
            phase <= 1'b0;
        end else if (en) begin
            phase <= ~phase;
        end
    end

    always_ff @(posedge clk_phy or negedge reset) begin
        if (!reset) begin
            low_nib <= 4'h0;
        end else if (en && !phase) begin
            low_nib <= nib_in;
        end
    end

    // Stage p0 -> p1: assembled byte registered with its one-cycle valid.
    always_ff @(posedge clk_phy or negedge reset) begin
        if (!reset) begin
            data_out   <= 8'h00;
            data_valid <= 1'b0;
        end else begin
            data_valid <= byte_done && !clear;
            if (byte_done && !clear) begin
                data_out <= {nib_in, low_nib};
            end
        end
    end

endmodule

// File: rtl/phy_rx_deframer.sv
// Receive deframer: strips preamble/SFD, emits bytes, and reports frame
// length plus a discard flag at end of frame.
module phy_rx_deframer
    import eth_frame_pkg::*;
#(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 2047
) (
    input  logic                clk_phy,
    input  logic                reset,
    input  logic [3:0]          phy_data_in,
    input  logic                phy_rx_dv,
    output logic [7:0]          f_data_out,
    output logic                f_rec_data_valid,
    output logic [CTRL_W-1:0]   f_ctrl_out,
    output logic                f_rec_frame_valid,
    output logic                f_frame_err
);

    localparam logic [LEN_W-1:0] MIN_LEN_L = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    rx_state_t        state;
    rx_state_t        state_nxt;
    logic             sfd_seen;
    logic             pack_en;
    logic             frame_end;
    logic             phase;
    logic             byte_done;
    logic [LEN_W-1:0] byte_cnt;

    function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] cnt);
        return (cnt == LEN_SAT) ? cnt : cnt + 1'b1;
    endfunction

    // A trailing half byte or an out-of-range length both mark the frame bad.
    function automatic logic frame_bad(input logic [LEN_W-1:0] len,
                                       input logic             odd_nib);
        return odd_nib || (len < MIN_LEN_L) || (len > MAX_LEN_L);
    endfunction

    always_ff @(posedge clk_phy or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (phy_rx_dv) begin
                    state_nxt = (phy_data_in == PREAMBLE_NIB) ? PREAMBLE : DROP;
                end
            end
            PREAMBLE: begin
                if (!phy_rx_dv) begin
                    state_nxt = IDLE;
                end else if (phy_data_in == SFD_HI_NIB) begin
                    state_nxt = DATA;
                end else if (phy_data_in != PREAMBLE_NIB) begin
                    state_nxt = DROP;
                end
            end
            DATA: begin
                if (!phy_rx_dv) begin
                    state_nxt = IDLE;
                end
            end
            DROP: begin
                if (!phy_rx_dv) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // PREAMBLE is only ever entered or held on a 5, so a D there always follows a 5.
    always_comb begin
        sfd_seen  = 1'b0;
        pack_en   = 1'b0;
        frame_end = 1'b0;
        unique case (state)
            PREAMBLE: sfd_seen  = phy_rx_dv && (phy_data_in == SFD_HI_NIB);
            DATA: begin
                pack_en   = phy_rx_dv;
                frame_end = !phy_rx_dv;
            end
            default: ;
        endcase
    end

    rx_nibble_pack u_pack (
        .clk_phy    (clk_phy),
        .reset      (reset),
        .clear      (sfd_seen),
        .en         (pack_en),
        .nib_in     (phy_data_in),
        .phase      (phase),
        .byte_done  (byte_done),
        .data_out   (f_data_out),
        .data_valid (f_rec_data_valid)
    );

    always_ff @(posedge clk_phy or negedge reset) begin
        if (!reset) begin
            byte_cnt <= '0;
        end else if (sfd_seen) begin
            byte_cnt <= '0;
        end else if (byte_done) begin
            byte_cnt <= sat_inc(byte_cnt);
        end
    end

    // Stage p0 -> p1: end-of-frame pulse; ctrl and error hold until the next frame.
    always_ff @(posedge clk_phy or negedge reset) begin
        if (!reset) begin
            f_rec_frame_valid <= 1'b0;
            f_ctrl_out        <= '0;
            f_frame_err       <= 1'b0;
        end else begin
            f_rec_frame_valid <= frame_end;
            if (frame_end) begin
                f_ctrl_out  <= pack_ctrl(byte_cnt);
                f_frame_err <= frame_bad(byte_cnt, phase);
            end
        end
    end

endmodule

// File: tb/tb_phy_rx_deframer.sv
// Scoreboard bench for phy_rx_deframer: directed frames push expected bytes
// and end-of-frame results; a negedge monitor pops and compares.
module tb_phy_rx_deframer;

    logic        clk_phy = 1'b0;
    logic        reset   = 1'b0;
    logic [3:0]  phy_data_in = 4'h0;
    logic        phy_rx_dv   = 1'b0;
    logic [7:0]  f_data_out;
    logic        f_rec_data_valid;
    logic [23:0] f_ctrl_out;
    logic        f_rec_frame_valid;
    logic        f_frame_err;

    logic [7:0]  exp_bytes[$];
    logic [24:0] exp_frames[$];

    int  n_chk  = 0;
    int  n_fail = 0;
    bit  prev_byte_vld = 1'b0;
    bit  final_req = 1'b0;
    bit  done = 1'b0;

    phy_rx_deframer #(.MIN_LEN(64), .MAX_LEN(2047)) dut (
        .clk_phy           (clk_phy),
        .reset             (reset),
        .phy_data_in       (phy_data_in),
        .phy_rx_dv         (phy_rx_dv),
        .f_data_out        (f_data_out),
        .f_rec_data_valid  (f_rec_data_valid),
        .f_ctrl_out        (f_ctrl_out),
        .f_rec_frame_valid (f_rec_frame_valid),
        .f_frame_err       (f_frame_err)
    );

    always #5 clk_phy = ~clk_phy;

    // Monitor: all checking happens here, on the falling edge.
    always @(negedge clk_phy) begin
        logic [7:0]  eb;
        logic [24:0] ef;
        if (!reset) begin
            n_chk++;
            if (f_data_out !== 8'h00 || f_rec_data_valid !== 1'b0 || f_ctrl_out !== 24'h0 ||
                f_rec_frame_valid !== 1'b0 || f_frame_err !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_outputs: got data=%h dv=%b ctrl=%h fv=%b err=%b, want all 0",
                         f_data_out, f_rec_data_valid, f_ctrl_out, f_rec_frame_valid, f_frame_err);
            end
            prev_byte_vld = 1'b0;
        end else begin
            if (f_rec_data_valid) begin
                n_chk++;
                if (exp_bytes.size() == 0) begin
                    n_fail++;
                    $display("FAIL byte_unexpected: got %h, want no byte pulse", f_data_out);
                end else begin
                    eb = exp_bytes.pop_front();
                    if (f_data_out !== eb || prev_byte_vld) begin
                        n_fail++;
                        $display("FAIL byte_data: got %h (back-to-back=%b), want %h (spaced)",
                                 f_data_out, prev_byte_vld, eb);
                    end
                end
            end
            prev_byte_vld = f_rec_data_valid;
            if (f_rec_frame_valid) begin
                n_chk++;
                if (exp_frames.size() == 0) begin
                    n_fail++;
                    $display("FAIL frame_unexpected: got ctrl=%h err=%b, want no frame pulse",
                             f_ctrl_out, f_frame_err);
                end else begin
                    ef = exp_frames.pop_front();
                    if ({f_frame_err, f_ctrl_out} !== ef || exp_bytes.size() != 0) begin
                        n_fail++;
                        $display("FAIL frame_ctrl: got ctrl=%h err=%b pending_bytes=%0d, want ctrl=%h err=%b pending_bytes=0",
                                 f_ctrl_out, f_frame_err, exp_bytes.size(), ef[23:0], ef[24]);
                    end
                end
            end
        end
        if (final_req && !done) begin
            n_chk++;
            if (exp_bytes.size() != 0 || exp_frames.size() != 0) begin
                n_fail++;
                $display("FAIL drain: got %0d bytes %0d frames outstanding, want 0 and 0",
                         exp_bytes.size(), exp_frames.size());
            end
            done = 1'b1;
        end
    end

    task automatic send_nib(input logic [3:0] n, input logic dv);
        @(posedge clk_phy);
        #1;
        phy_data_in = n;
        phy_rx_dv   = dv;
    endtask

    task automatic send_preamble();
        for (int k = 0; k < 15; k++) send_nib(4'h5, 1'b1);
        send_nib(4'hD, 1'b1);
    endtask

    // Bytes carry the pattern 0x00,0x01,... wrapping at 0xFF.
    task automatic send_frame(input int nbytes, input bit odd,
                              input logic [23:0] ctrl, input logic err);
        logic [7:0] b;
        send_preamble();
        for (int i = 0; i < nbytes; i++) begin
            b = 8'(i);
            exp_bytes.push_back(b);
            send_nib(b[3:0], 1'b1);
            send_nib(b[7:4], 1'b1);
        end
        if (odd) send_nib(4'h7, 1'b1);
        exp_frames.push_back({err, ctrl});
        send_nib(4'h0, 1'b0);
    endtask

    task automatic send_aborted_frame(input int nbytes_before_reset);
        logic [7:0] b;
        send_preamble();
        for (int i = 0; i < nbytes_before_reset; i++) begin
            b = 8'(i);
            exp_bytes.push_back(b);
            send_nib(b[3:0], 1'b1);
            send_nib(b[7:4], 1'b1);
        end
        send_nib(4'h1, 1'b1);
        @(posedge clk_phy);
        #1;
        reset     = 1'b0;
        phy_rx_dv = 1'b0;
        repeat (3) @(posedge clk_phy);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk_phy);
        #1;
        reset = 1'b1;
        repeat (2) send_nib(4'h0, 1'b0);

        send_frame(512, 1'b0, 24'h200200, 1'b0);
        for (int f = 0; f < 16; f++) send_frame(512, 1'b0, 24'h200200, 1'b0);
        send_frame(40, 1'b0, 24'h028028, 1'b1);
        send_frame(64, 1'b0, 24'h040040, 1'b0);
        send_frame(63, 1'b0, 24'h03F03F, 1'b1);
        send_frame(100, 1'b1, 24'h064064, 1'b1);
        send_frame(0, 1'b0, 24'h000000, 1'b1);

        send_nib(4'h5, 1'b1);
        send_nib(4'h5, 1'b1);
        send_nib(4'hA, 1'b1);
        send_nib(4'h5, 1'b1);
        send_nib(4'hD, 1'b1);
        send_nib(4'h0, 1'b0);
        send_frame(64, 1'b0, 24'h040040, 1'b0);

        send_nib(4'h3, 1'b1);
        send_nib(4'h5, 1'b1);
        send_nib(4'h0, 1'b0);
        send_frame(64, 1'b0, 24'h040040, 1'b0);

        send_aborted_frame(30);
        send_nib(4'h0, 1'b0);
        send_frame(64, 1'b0, 24'h040040, 1'b0);

        send_frame(2047, 1'b0, 24'h7FF7FF, 1'b0);
        send_frame(2048, 1'b0, 24'h800800, 1'b1);
        send_frame(4100, 1'b0, 24'hFFFFFF, 1'b1);

        repeat (6) send_nib(4'h0, 1'b0);
        final_req = 1'b1;
        for (int w = 0; w < 20 && !done; w++) @(posedge clk_phy);
        if (!done) begin
            $display("FAIL drain_timeout: got no final check, want final check");
            $fatal(1, "final check not reached");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
